kf_adapt_noise_est: RTL and testbench

// - Multi-channel adaptive noise estimator feeding the top_kf update stage: per frame, updates exponentially

---
 rtl/kf_pkg.sv | 37 +++
 rtl/kf_fxp_mul_sat.sv | 27 ++
 rtl/kf_adapt_noise_est.sv | 206 ++++++++++++++++++++
 tb/tb_kf_adapt_noise_est.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/kf_pkg.sv
// kf_pkg: shared constants and helpers for the adaptive noise estimator.
//   N_DEF / FRAC_DEF : default fixed-point format Q(20,10)
//   ONE              : 1.0 in the default format
//   ST_*             : estimator FSM state encodings
//   S0..S4           : per-channel micro-step codes
//   sat_n / sat_hit  : clamp a wide signed value to an n-bit signed range
package kf_pkg;

  localparam int N_DEF    = 20;
  localparam int FRAC_DEF = 10;
  localparam int ONE      = 1 << FRAC_DEF;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  localparam logic [2:0] S0 = 3'd0;  // d2  = z*z
  localparam logic [2:0] S1 = 3'd1;  // sd  += omb*(d2 - sd)
  localparam logic [2:0] S2 = 3'd2;  // zh2 = zh*zh
  localparam logic [2:0] S3 = 3'd3;  // szh += omb*(zh2 - szh)
  localparam logic [2:0] S4 = 3'd4;  // acc += dx*dx

  function automatic logic signed [63:0] sat_n(input logic signed [63:0] x, input int n);
    logic signed [63:0] mx;
    logic signed [63:0] mn;
    mx = (64'sd1 <<< (n - 1)) - 64'sd1;
    mn = -(64'sd1 <<< (n - 1));
    if (x > mx)      return mx;
    else if (x < mn) return mn;
    else             return x;
  endfunction

  function automatic logic sat_hit(input logic signed [63:0] x, input int n);
    return sat_n(x, n) != x;
  endfunction

endpackage

// File: rtl/kf_fxp_mul_sat.sv
// kf_fxp_mul_sat: combinational Q(N,FRAC) multiply.
//   a, b : signed operands
//   y    : floor((a*b) / 2^FRAC) clamped to N bits
//   sat  : high when the clamp was applied
module kf_fxp_mul_sat #(
  parameter int N    = 20,
  parameter int FRAC = 10
) (
  input  logic signed [N-1:0] a,
  input  logic signed [N-1:0] b,
  output logic signed [N-1:0] y,
  output logic                sat
);

  logic signed [2*N-1:0] prod;
  logic signed [2*N-1:0] shd;
  logic        [N:0]     hi;

  assign prod = (2*N)'(a) * (2*N)'(b);
  assign shd  = prod >>> FRAC;
  // The result fits in N bits only if the top N+1 bits are all sign copies.
  assign hi   = shd[2*N-1:N-1];
  assign sat  = !((&hi) || !(|hi));
  assign y    = !sat ? shd[N-1:0]
              : (shd[2*N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}});

endmodule

// File: rtl/kf_adapt_noise_est.sv
// kf_adapt_noise_est: per-frame adaptive R/Q estimator, CH channels sharing one multiplier.
//   clk, rst_n        : clock, synchronous active-low reset
//   start, init_load  : frame request / load sigma_init into all variance registers (IDLE only)
//   sigma_init, beta  : start-up variance, forgetting factor Q(N,FRAC)
//   z_meas, z_hat, dx : packed per-channel inputs, channel i at [i*N +: N]
//   busy, done        : frame in progress / one-cycle result strobe
//   r_est, q_est      : per-channel |sigma2_d - sigma2_zh|, mean(dx^2); held between frames
//   sat               : sticky saturation flag for the current frame
//
// state   | meaning
// IDLE    | waiting for start / init_load
// RUN     | 5 micro-steps per channel, channels ascending
// FIN     | results committed, done high; returns to IDLE
module kf_adapt_noise_est
  import kf_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int FRAC = FRAC_DEF,
  parameter int CH   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            init_load,
  input  logic [N-1:0]    sigma_init,
  input  logic [N-1:0]    beta,
  input  logic [CH*N-1:0] z_meas,
  input  logic [CH*N-1:0] z_hat,
  input  logic [CH*N-1:0] dx,
  output logic            busy,
  output logic            done,
  output logic [CH*N-1:0] r_est,
  output logic [N-1:0]    q_est,
  output logic            sat
);

  localparam int CW = (CH > 1) ? $clog2(CH) : 1;
  localparam int SH = $clog2(CH);
  localparam logic signed [N-1:0] ONE_N = N'(64'sd1 <<< FRAC);
  localparam logic signed [N-1:0] MAX_N = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0] MIN_N = {1'b1, {(N-1){1'b0}}};

  logic [1:0]          state;
  logic [2:0]          step;
  logic [CW-1:0]       ch;
  logic [CH*N-1:0]     zq, zhq, dxq;
  logic signed [N-1:0] omb, tmp;
  logic signed [N-1:0] sd  [CH];
  logic signed [N-1:0] szh [CH];
  logic signed [N+2:0] acc;

  logic signed [N-1:0] z_c, zh_c, dx_c, sd_c, szh_c;
  logic signed [N-1:0] base, diff, ma, mb, prod, upd, omb_nx, q_nx, rd;
  logic signed [63:0]  t_diff, t_upd, t_omb, t_q, t_r;
  logic signed [N+2:0] acc_nx;
  logic [CH*N-1:0]     r_nx;
  logic                mul_sat, diff_sat, upd_sat, omb_sat, step_sat, fin_sat, last;

  // Current-channel operand select.
  always_comb begin
    z_c   = '0;
    zh_c  = '0;
    dx_c  = '0;
    sd_c  = '0;
    szh_c = '0;
    for (int i = 0; i < CH; i++) begin
      if (ch == CW'(i)) begin
        z_c   = zq[i*N +: N];
        zh_c  = zhq[i*N +: N];
        dx_c  = dxq[i*N +: N];
        sd_c  = sd[i];
        szh_c = szh[i];
      end
    end
  end

  // Multiplier input mux; the innovation (square - variance) is formed here.
  always_comb begin
    base     = (step == S1) ? sd_c : szh_c;
    t_diff   = 64'(tmp) - 64'(base);
    diff     = N'(sat_n(t_diff, N));
    diff_sat = sat_hit(t_diff, N);
    case (step)
      S0:      begin ma = z_c;  mb = z_c;  end
      S1, S3:  begin ma = omb;  mb = diff; end
      S2:      begin ma = zh_c; mb = zh_c; end
      default: begin ma = dx_c; mb = dx_c; end
    endcase
  end

  kf_fxp_mul_sat #(.N(N), .FRAC(FRAC)) u_mul (
    .a   (ma),
    .b   (mb),
    .y   (prod),
    .sat (mul_sat)
  );

  always_comb begin
    t_upd   = 64'(base) + 64'(prod);
    upd     = N'(sat_n(t_upd, N));
    upd_sat = sat_hit(t_upd, N);
    case (step)
      S1, S3:  step_sat = diff_sat | mul_sat | upd_sat;
      default: step_sat = mul_sat;
    endcase
    t_omb   = 64'(ONE_N) - 64'($signed(beta));
    omb_nx  = N'(sat_n(t_omb, N));
    omb_sat = sat_hit(t_omb, N);
    last    = (step == S4) && (ch == CW'(CH - 1));
    // acc has 3 guard bits, enough for 8 non-negative squares without wrap.
    acc_nx  = acc + (N+3)'(prod);
    t_q     = 64'(acc_nx) >>> SH;
    q_nx    = N'(sat_n(t_q, N));
    fin_sat = sat_hit(t_q, N);
    r_nx    = '0;
    t_r     = '0;
    rd      = '0;
    for (int i = 0; i < CH; i++) begin
      t_r     = 64'(sd[i]) - 64'(szh[i]);
      rd      = N'(sat_n(t_r, N));
      fin_sat = fin_sat | sat_hit(t_r, N);
      if (rd == MIN_N) begin
        r_nx[i*N +: N] = MAX_N;
        fin_sat        = 1'b1;
      end else begin
        r_nx[i*N +: N] = rd[N-1] ? -rd : rd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      step  <= S0;
      ch    <= '0;
      zq    <= '0;
      zhq   <= '0;
      dxq   <= '0;
      omb   <= '0;
      tmp   <= '0;
      acc   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sat   <= 1'b0;
      r_est <= '0;
      q_est <= '0;
      for (int i = 0; i < CH; i++) begin
        sd[i]  <= '0;
        szh[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (init_load) begin
            for (int i = 0; i < CH; i++) begin
              sd[i]  <= sigma_init;
              szh[i] <= sigma_init;
            end
          end else if (start) begin
            zq    <= z_meas;
            zhq   <= z_hat;
            dxq   <= dx;
            omb   <= omb_nx;
            sat   <= omb_sat;
            acc   <= '0;
            step  <= S0;
            ch    <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          sat <= sat | step_sat;
          case (step)
            S0, S2: tmp <= prod;
            S1: for (int i = 0; i < CH; i++) if (ch == CW'(i)) sd[i] <= upd;
            S3: for (int i = 0; i < CH; i++) if (ch == CW'(i)) szh[i] <= upd;
            S4: acc <= acc_nx;
            default: ;
          endcase
          if (step == S4) begin
            step <= S0;
            if (last) begin
              r_est <= r_nx;
              q_est <= q_nx;
              done  <= 1'b1;
              sat   <= sat | step_sat | fin_sat;
              state <= ST_FIN;
            end else begin
              ch <= ch + CW'(1);
            end
          end else begin
            step <= step + 3'd1;
          end
        end
        ST_FIN: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kf_adapt_noise_est.sv
module tb_kf_adapt_noise_est;

  localparam int N    = 20;
  localparam int FRAC = 10;
  localparam int CH   = 2;
  localparam longint MAXV  = (64'sd1 <<< (N - 1)) - 1;
  localparam longint MINV  = -(64'sd1 <<< (N - 1));
  localparam longint ONE_Q = 64'sd1 <<< FRAC;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            init_load = 1'b0;
  logic [N-1:0]    sigma_init = '0;
  logic [N-1:0]    beta = '0;
  logic [CH*N-1:0] z_meas = '0;
  logic [CH*N-1:0] z_hat = '0;
  logic [CH*N-1:0] dx = '0;
  logic            busy, done, sat;
  logic [CH*N-1:0] r_est;
  logic [N-1:0]    q_est;

  kf_adapt_noise_est #(.N(N), .FRAC(FRAC), .CH(CH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .init_load  (init_load),
    .sigma_init (sigma_init),
    .beta       (beta),
    .z_meas     (z_meas),
    .z_hat      (z_hat),
    .dx         (dx),
    .busy       (busy),
    .done       (done),
    .r_est      (r_est),
    .q_est      (q_est),
    .sat        (sat)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: estimator state and last committed outputs.
  longint sd_m[CH], szh_m[CH], r_m[CH], q_m;
  bit     sat_m, fl;
  longint zv[CH], zhv[CH], dxv[CH], bv;

  function automatic longint clip(input longint x);
    if (x > MAXV) begin fl = 1'b1; return MAXV; end
    if (x < MINV) begin fl = 1'b1; return MINV; end
    return x;
  endfunction

  function automatic longint fmul(input longint a, input longint b);
    return clip((a * b) >>> FRAC);
  endfunction

  task automatic model_frame();
    longint omb, acc, d;
    fl  = 1'b0;
    omb = clip(ONE_Q - bv);
    acc = 0;
    for (int i = 0; i < CH; i++) begin
      d        = fmul(zv[i], zv[i]);
      sd_m[i]  = clip(sd_m[i] + fmul(omb, clip(d - sd_m[i])));
      d        = fmul(zhv[i], zhv[i]);
      szh_m[i] = clip(szh_m[i] + fmul(omb, clip(d - szh_m[i])));
      acc      = acc + fmul(dxv[i], dxv[i]);
    end
    q_m = clip(acc / CH);
    for (int i = 0; i < CH; i++) begin
      d = clip(sd_m[i] - szh_m[i]);
      if (d == MINV) begin
        fl     = 1'b1;
        r_m[i] = MAXV;
      end else begin
        r_m[i] = (d < 0) ? -d : d;
      end
    end
    sat_m = fl;
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      sd_m[i] = 0; szh_m[i] = 0; r_m[i] = 0;
    end
    q_m   = 0;
    sat_m = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    for (int i = 0; i < CH; i++)
      check($sformatf("%s_r%0d", tag, i), longint'($signed(r_est[i*N +: N])), r_m[i]);
    check({tag, "_q"}, longint'($signed(q_est)), q_m);
    check({tag, "_sat"}, longint'(sat), longint'(sat_m));
  endtask

  task automatic do_init(input longint v);
    @(negedge clk);
    sigma_init = v[N-1:0];
    init_load  = 1'b1;
    @(posedge clk);
    #1 init_load = 1'b0;
    for (int i = 0; i < CH; i++) begin
      sd_m[i] = v; szh_m[i] = v;
    end
  endtask

  // Runs one frame. ext_start>0 pulses start again in that cycle;
  // rst_at>0 pulls reset low in that cycle to abort the frame.
  task automatic do_frame(input string tag, input int ext_start, input int rst_at);
    int  done_cnt, done_at, busy_bad;
    bit  exp_busy;
    done_cnt = 0;
    done_at  = -1;
    busy_bad = 0;
    @(negedge clk);
    for (int i = 0; i < CH; i++) begin
      z_meas[i*N +: N] = zv[i][N-1:0];
      z_hat[i*N +: N]  = zhv[i][N-1:0];
      dx[i*N +: N]     = dxv[i][N-1:0];
    end
    beta  = bv[N-1:0];
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    if (rst_at > 0) model_reset();
    else            model_frame();
    for (int k = 1; k <= 5*CH + 6; k++) begin
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      exp_busy = (rst_at > 0) ? (k <= rst_at) : (k <= 5*CH + 1);
      if (busy !== exp_busy) busy_bad++;
      if (k == ext_start) start = 1'b1;
      if (k == rst_at)    rst_n = 1'b0;
      @(posedge clk);
      #1;
      start = 1'b0;
      rst_n = 1'b1;
    end
    if (rst_at > 0) begin
      check({tag, "_no_done"}, done_cnt, 0);
    end else begin
      check({tag, "_done_cnt"}, done_cnt, 1);
      check({tag, "_done_cycle"}, done_at, 5*CH + 1);
    end
    check({tag, "_busy_trace"}, busy_bad, 0);
    check_outputs(tag);
  endtask

  function automatic longint rnd_val(input bit wide);
    if (wide) return longint'($urandom_range(0, (1 << N) - 1)) - (64'sd1 <<< (N - 1));
    return longint'($urandom_range(0, 8191)) - 4096;
  endfunction

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int  dn, bz;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check_outputs("rst");
    rst_n = 1'b1;

    do_init(40);
    zv[0] = 1280; zv[1] = -819;
    zhv[0] = 0;   zhv[1] = 0;
    dxv[0] = 1024; dxv[1] = 512;
    bv = 921;
    do_frame("basic", 0, 0);
    do_frame("persist", 0, 0);

    zv[0] = 524287; zv[1] = 0;
    do_frame("satur", 0, 0);

    zv[0] = 300; zv[1] = -200; zhv[0] = 150; zhv[1] = 90;
    do_frame("busy_start", 4, 0);
    do_frame("fin_start", 11, 0);

    // init_load and start together: load wins, no frame.
    @(negedge clk);
    sigma_init = 20'd77;
    init_load  = 1'b1;
    start      = 1'b1;
    @(posedge clk);
    #1 init_load = 1'b0;
    start = 1'b0;
    for (int i = 0; i < CH; i++) begin
      sd_m[i] = 77; szh_m[i] = 77;
    end
    dn = 0; bz = 0;
    for (int k = 0; k < 5*CH + 6; k++) begin
      if (done === 1'b1) dn++;
      if (busy !== 1'b0) bz++;
      @(posedge clk);
      #1;
    end
    check("load_start_done", dn, 0);
    check("load_start_busy", bz, 0);
    check_outputs("load_start_hold");
    do_frame("after_load", 0, 0);

    do_frame("mid_reset", 0, 5);
    zv[0] = 1280; zv[1] = -819; zhv[0] = 0; zhv[1] = 0;
    do_frame("post_reset", 0, 0);

    for (int it = 0; it < 20; it++) begin
      if ($urandom_range(0, 3) == 0) do_init(longint'($urandom_range(0, 4000)));
      for (int i = 0; i < CH; i++) begin
        zv[i]  = rnd_val($urandom_range(0, 5) == 0);
        zhv[i] = rnd_val($urandom_range(0, 5) == 0);
        dxv[i] = rnd_val($urandom_range(0, 5) == 0);
      end
      if ($urandom_range(0, 7) == 0) bv = rnd_val(1'b1);
      else                           bv = longint'($urandom_range(0, 1200));
      do_frame($sformatf("rand%0d", it), 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
